fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage upstream of the instruction memory. It holds the PC and drives the 8-bit byte address into the combinational instruction ROM. It captures the returned word into an IF/ID output register with a valid flag, for the decoder and register file downstream. It also supports stall, branch/jump redirect with bubble insertion, and halt on an all-zero (unmapped) instruction word.

Parameters:
AW, 8, instruction-memory byte-address width driven on imem_addr
XLEN, 32, PC and instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_addr  output  AW  byte address to instruction memory, equals pc_r[AW-1:0] combinationally
imem_rdata  input  XLEN  instruction word from memory, same-cycle combinational return
stall  input  1  hold PC and output register
redirect_valid  input  1  load redirect_target into PC this cycle
redirect_target  input  XLEN  new PC (branch/jump target)
if_pc  output  XLEN  PC of the instruction in if_instr
if_pc_plus4  output  XLEN  if_pc + 4
if_instr  output  XLEN  registered instruction word
if_valid  output  1  if_instr/if_pc hold a real instruction
halted  output  1  high while the FSM is in HALT
misalign_err  output  1  sticky misaligned-redirect flag; tied 0 unless FETCH_MISALIGN_CHECK_EN

Behaviour:
- Reset (async, any time, including mid-operation): pc_r=RESET_PC, state=BOOT, if_pc=0, if_pc_plus4=0, if_instr=0, if_valid=0, halted=0, misalign_err=0.
- FSM states: BOOT, RUN, HALT.
  - BOOT: lasts one cycle after reset release. No capture, if_valid=0. Goes to RUN.
  - RUN: fetches one instruction per non-stalled cycle.
  - HALT: pc_r frozen, if_valid=0, halted=1. Leaves only on redirect_valid, going to RUN with pc_r=target.
- RUN priority per cycle: redirect > stall > advance.
- Advance (stall=0, redirect_valid=0):
  - if_instr<=imem_rdata, if_pc<=pc_r, if_pc_plus4<=pc_r+4, if_valid<=1.
  - pc_r<=pc_r+4.
  - Latency: address presented in cycle N; instruction visible on if_instr in cycle N+1.
- Halt detect: on an advance with imem_rdata==0, the all-zero word is not captured. if_valid<=0, pc_r holds, next state HALT.
- Stall (redirect_valid=0): pc_r and all if_* registers hold. if_valid is unchanged, so the downstream stage sees the same instruction.
- Redirect:
  - pc_r<=target with bits [1:0] forced to 0; if_valid<=0 (one bubble).
  - The word at the old PC is discarded.
  - Redirect overrides stall in the same cycle.
  - Redirect during BOOT is ignored.
- Wrap-around:
  - pc_r is full XLEN and wraps modulo 2^32.
  - imem_addr truncates to AW bits, so PC 0x100 addresses byte 0x00.
  - No error is raised for truncation.
- Arithmetic is unsigned XLEN-bit; the +4 carry-out is dropped.

Optional Feature:
FETCH_MISALIGN_CHECK_EN:
- Defined: a redirect with target[1:0]!=0 is rejected. pc_r holds, misalign_err<=1 (sticky until rst), if_valid<=0, state->HALT.
  - A later aligned redirect leaves HALT; misalign_err stays set.
- Undefined: bits [1:0] are silently cleared and misalign_err is tied 0.

Decomposition:
- Package fetch_pkg holds:
  - typedef enum logic [1:0] fetch_state_t {BOOT, RUN, HALT}
  - localparam INSTR_ZERO=32'h0
  - localparam PC_STEP=4
  - the default RESET_PC
- One sub-module, fetch_pc_reg: PC register plus next-PC mux (pc+4 / aligned target / hold).
- The FSM and the IF/ID register stay in fetch_unit.

Test Plan:
- Reset then run against a memory holding 0x00300093 @0x00 and 0x00900113 @0x04 -> imem_addr 0x00 during BOOT. Cycle 2: if_instr=0x00300093, if_pc=0, if_pc_plus4=4, if_valid=1. Cycle 3: if_instr=0x00900113, if_pc=4.
- stall=1 for 3 cycles with if_pc=0x04 -> imem_addr, if_pc and if_instr unchanged for all 3 cycles; if_valid stays 1. On release, if_pc=0x08 next cycle.
- Redirect to 0x10 together with stall=1 -> next cycle if_valid=0, imem_addr=0x10. Following cycle if_pc=0x10, if_valid=1.
- Fetch reaches 0x1C returning 0 -> if_valid=0, halted=1, imem_addr stuck at 0x1C. A redirect to 0x00 then resumes with if_pc=0 one cycle later.
- Assert rst mid-run at pc=0x0C -> all outputs zero immediately (asynchronously). After release: BOOT for one cycle, then fetch resumes from RESET_PC.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x0A -> misalign_err=1, halted=1, pc unchanged. Without the macro -> imem_addr=0x08, misalign_err=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_TARGET
  } pc_sel_t;

  localparam logic [31:0] INSTR_ZERO       = 32'h0;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC select: hold, +4, or word-aligned redirect target.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    case (pc_sel)
      PC_INC:    pc_d = pc_q + XLEN'(PC_STEP);
      PC_TARGET: pc_d = {target[XLEN-1:2], 2'b00};
      default:   pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IF/ID register, stall/redirect/halt control.
// Optional FETCH_MISALIGN_CHECK_EN rejects misaligned redirects and raises a sticky error.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     AW       = 8,
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic [AW-1:0]   imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [XLEN-1:0] if_instr,
  output logic            if_valid,
  output logic            halted,
  output logic            misalign_err
);

  fetch_state_t    state_d, state_q;
  pc_sel_t         pc_sel;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] if_pc_d, if_pc_q;
  logic [XLEN-1:0] if_pc_plus4_d, if_pc_plus4_q;
  logic [XLEN-1:0] if_instr_d, if_instr_q;
  logic            if_valid_d, if_valid_q;
  logic            misalign_err_d, misalign_err_q;
  logic            target_bad;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target_bad = |redirect_target[1:0];
`else
  assign target_bad = 1'b0;
`endif

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .pc_sel (pc_sel),
    .target (redirect_target),
    .pc     (pc_r)
  );

  always_comb begin
    state_d        = state_q;
    pc_sel         = PC_HOLD;
    if_pc_d        = if_pc_q;
    if_pc_plus4_d  = if_pc_plus4_q;
    if_instr_d     = if_instr_q;
    if_valid_d     = if_valid_q;
    misalign_err_d = misalign_err_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_valid) begin
          if_valid_d = 1'b0;
          if (target_bad) begin
            misalign_err_d = 1'b1;
            state_d        = HALT;
          end else begin
            pc_sel = PC_TARGET;
          end
        end else if (!stall) begin
          // An all-zero word marks unmapped memory: stop instead of capturing it.
          if (imem_rdata == XLEN'(INSTR_ZERO)) begin
            if_valid_d = 1'b0;
            state_d    = HALT;
          end else begin
            if_instr_d    = imem_rdata;
            if_pc_d       = pc_r;
            if_pc_plus4_d = pc_r + XLEN'(PC_STEP);
            if_valid_d    = 1'b1;
            pc_sel        = PC_INC;
          end
        end
      end
      HALT: begin
        if_valid_d = 1'b0;
        if (redirect_valid) begin
          if (target_bad) begin
            misalign_err_d = 1'b1;
          end else begin
            pc_sel  = PC_TARGET;
            state_d = RUN;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= BOOT;
      if_pc_q        <= '0;
      if_pc_plus4_q  <= '0;
      if_instr_q     <= '0;
      if_valid_q     <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      if_pc_q        <= if_pc_d;
      if_pc_plus4_q  <= if_pc_plus4_d;
      if_instr_q     <= if_instr_d;
      if_valid_q     <= if_valid_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign imem_addr    = pc_r[AW-1:0];
  assign if_pc        = if_pc_q;
  assign if_pc_plus4  = if_pc_plus4_q;
  assign if_instr     = if_instr_q;
  assign if_valid     = if_valid_q;
  assign halted       = (state_q == HALT);
  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed literal checks plus randomized traffic against a behavioural model.
module tb_fetch_unit;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MisEn = 1'b1;
`else
  localparam bit MisEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        stall, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] if_pc, if_pc_plus4, if_instr;
  logic        if_valid, halted, misalign_err;

  logic [31:0] mem [64];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          chk_on  = 1'b0;

  // Behavioural model: mode 0 boot, 1 running, 2 halted.
  logic [31:0] m_pc, m_ipc, m_ip4, m_instr;
  logic        m_v, m_err;
  int          m_mode;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[7:2]];

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .if_instr        (if_instr),
    .if_valid        (if_valid),
    .halted          (halted),
    .misalign_err    (misalign_err)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 32'h0; m_ipc <= 32'h0; m_ip4 <= 32'h0; m_instr <= 32'h0;
      m_v <= 1'b0; m_err <= 1'b0; m_mode <= 0;
    end else if (m_mode == 0) begin
      m_mode <= 1;
    end else if (redirect_valid) begin
      m_v <= 1'b0;
      if (MisEn && redirect_target[1:0] != 2'b00) begin
        m_err <= 1'b1;
        m_mode <= 2;
      end else begin
        m_pc <= redirect_target & 32'hFFFF_FFFC;
        m_mode <= 1;
      end
    end else if (m_mode == 2) begin
      m_v <= 1'b0;
    end else if (!stall) begin
      if (mem[m_pc[7:2]] == 32'h0) begin
        m_v <= 1'b0;
        m_mode <= 2;
      end else begin
        m_instr <= mem[m_pc[7:2]];
        m_ipc <= m_pc;
        m_ip4 <= m_pc + 32'd4;
        m_v <= 1'b1;
        m_pc <= m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("imem_addr", {24'h0, imem_addr}, {24'h0, m_pc[7:0]});
      chk("if_pc", if_pc, m_ipc);
      chk("if_pc_plus4", if_pc_plus4, m_ip4);
      chk("if_instr", if_instr, m_instr);
      chk("if_valid", {31'h0, if_valid}, {31'h0, m_v});
      chk("halted", {31'h0, halted}, {31'h0, (m_mode == 2)});
      chk("misalign_err", {31'h0, misalign_err}, {31'h0, m_err});
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013 | (i << 20);
    mem[0] = 32'h0030_0093;
    mem[1] = 32'h0090_0113;
    mem[7] = 32'h0;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    #12;
    chk("rst if_valid", {31'h0, if_valid}, 32'h0);
    chk("rst if_instr", if_instr, 32'h0);
    chk("rst imem_addr", {24'h0, imem_addr}, 32'h0);
    chk_on = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    chk("boot imem_addr", {24'h0, imem_addr}, 32'h0);
    cyc();
    chk("boot no capture", {31'h0, if_valid}, 32'h0);
    cyc();
    chk("first instr", if_instr, 32'h0030_0093);
    chk("first pc", if_pc, 32'h0);
    chk("first pc+4", if_pc_plus4, 32'h4);
    chk("first valid", {31'h0, if_valid}, 32'h1);
    cyc();
    chk("second instr", if_instr, 32'h0090_0113);
    chk("second pc", if_pc, 32'h4);

    #1 stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall if_pc", if_pc, 32'h4);
      chk("stall addr", {24'h0, imem_addr}, 32'h8);
      chk("stall instr", if_instr, 32'h0090_0113);
      chk("stall valid", {31'h0, if_valid}, 32'h1);
    end
    #1 stall = 1'b0;
    cyc();
    chk("release if_pc", if_pc, 32'h8);

    #1 begin stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h10; end
    cyc();
    chk("redir bubble", {31'h0, if_valid}, 32'h0);
    chk("redir addr", {24'h0, imem_addr}, 32'h10);
    #1 begin stall = 1'b0; redirect_valid = 1'b0; end
    cyc();
    chk("redir if_pc", if_pc, 32'h10);
    chk("redir valid", {31'h0, if_valid}, 32'h1);
    cyc();
    cyc();
    cyc();
    chk("halt valid", {31'h0, if_valid}, 32'h0);
    chk("halt flag", {31'h0, halted}, 32'h1);
    chk("halt addr", {24'h0, imem_addr}, 32'h1C);
    cyc();
    cyc();
    chk("halt stuck addr", {24'h0, imem_addr}, 32'h1C);
    #1 begin redirect_valid = 1'b1; redirect_target = 32'h0; end
    cyc();
    chk("unhalt", {31'h0, halted}, 32'h0);
    #1 redirect_valid = 1'b0;
    cyc();
    chk("resume if_pc", if_pc, 32'h0);
    cyc();
    cyc();
    chk("pre-reset addr", {24'h0, imem_addr}, 32'hC);

    #1 rst = 1'b1;
    #1;
    chk("async if_pc", if_pc, 32'h0);
    chk("async pc+4", if_pc_plus4, 32'h0);
    chk("async instr", if_instr, 32'h0);
    chk("async valid", {31'h0, if_valid}, 32'h0);
    chk("async addr", {24'h0, imem_addr}, 32'h0);
    @(negedge clk); #1 rst = 1'b0;
    cyc();
    chk("reboot bubble", {31'h0, if_valid}, 32'h0);
    cyc();
    chk("reboot instr", if_instr, 32'h0030_0093);
    cyc();

    #1 begin redirect_valid = 1'b1; redirect_target = 32'h0A; end
    cyc();
    chk("misalign addr", {24'h0, imem_addr}, 32'h8);
    chk("misalign err", {31'h0, misalign_err}, {31'h0, MisEn});
    chk("misalign halted", {31'h0, halted}, {31'h0, MisEn});
    #1 redirect_target = 32'h104;
    cyc();
    chk("trunc addr", {24'h0, imem_addr}, 32'h4);
    chk("err sticky", {31'h0, misalign_err}, {31'h0, MisEn});
    #1 redirect_target = 32'hFFFF_FFFC;
    cyc();
    #1 redirect_valid = 1'b0;
    cyc();
    chk("wrap if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap pc+4", if_pc_plus4, 32'h0);

    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1);
    for (int n = 0; n < 500; n++) begin
      #1;
      stall = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0, 1:    redirect_target = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        2:       redirect_target = $urandom;
        default: redirect_target = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      endcase
      if (n == 250) begin
        rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
